// File: rtl/tt_hamming_pkg.sv
// Shared widths and parity bit positions for the Hamming(7,4) encoder path.
package tt_hamming_pkg;

  localparam int DATA_W     = 4;
  localparam int CODE_W     = 7;
  localparam int FIFO_DEPTH = 2;

  // Parity bits sit at the power-of-two positions 1, 2 and 4 (0-based 0, 1, 3).
  localparam int P0_IDX = 0;
  localparam int P1_IDX = 1;
  localparam int P2_IDX = 3;

endpackage

// File: rtl/tt_hamming74_enc.sv
// Combinational Hamming(7,4) encoder: nibble in, codeword with zero syndrome out.
module tt_hamming74_enc
  import tt_hamming_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  output logic [CODE_W-1:0] code_o
);

  always_comb begin
    code_o         = '0;
    code_o[6]      = data_i[3];
    code_o[5]      = data_i[2];
    code_o[4]      = data_i[1];
    code_o[2]      = data_i[0];
    code_o[P0_IDX] = data_i[3] ^ data_i[1] ^ data_i[0];
    code_o[P1_IDX] = data_i[3] ^ data_i[2] ^ data_i[0];
    code_o[P2_IDX] = data_i[3] ^ data_i[2] ^ data_i[1];
  end

endmodule

// File: rtl/tt_sai_encoder.sv
// Hamming(7,4) encoder feeding a 2-entry valid/ready FIFO with a delivered-word counter.
// Optional single-bit error injection at push time is built when HAM_ERR_INJECT_EN is defined.
module tt_sai_encoder
  import tt_hamming_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code,
  input  logic              inj_en,
  input  logic [2:0]        inj_pos,
  output logic [15:0]       sent_count
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and ready depends only on registers.
  logic [CODE_W-1:0] mem_q [FIFO_DEPTH];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;
  logic [15:0]       sent_q, sent_d;
  logic              ready_en_q;
  logic [CODE_W-1:0] enc_code;
  logic [CODE_W-1:0] wr_code;
  logic              push;
  logic              pop;

  tt_hamming74_enc u_enc (
    .data_i (in_data),
    .code_o (enc_code)
  );

`ifdef HAM_ERR_INJECT_EN
  logic [CODE_W-1:0] inj_mask;

  always_comb begin
    inj_mask = '0;
    if (inj_en && (inj_pos != 3'd0)) inj_mask[inj_pos - 3'd1] = 1'b1;
  end

  assign wr_code = enc_code ^ inj_mask;
`else
  logic unused_inj;
  assign unused_inj = ^{inj_en, inj_pos};
  assign wr_code    = enc_code;
`endif

  // ready_en_q holds in_ready low while in reset and releases it one edge later.
  assign in_ready   = ready_en_q && (count_q < 2'(FIFO_DEPTH));
  assign out_valid  = (count_q != 2'd0);
  assign out_code   = mem_q[rd_ptr_q];
  assign sent_count = sent_q;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    sent_d   = sent_q;
    if (push) wr_ptr_d = ~wr_ptr_q;
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
      sent_d   = sent_q + 16'd1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      sent_q     <= 16'd0;
      ready_en_q <= 1'b0;
    end else begin
      if (push) mem_q[wr_ptr_q] <= wr_code;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      sent_q     <= sent_d;
      ready_en_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tt_sai_encoder.sv
// Directed, table-driven bench for tt_sai_encoder with a scoreboard for streaming.
module tb_tt_sai_encoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [6:0]  out_code;
  logic        inj_en;
  logic [2:0]  inj_pos;
  logic [15:0] sent_count;

  tt_sai_encoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_code   (out_code),
    .inj_en     (inj_en),
    .inj_pos    (inj_pos),
    .sent_count (sent_count)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] d;
    logic [6:0] code;
  } vec_t;

  vec_t       tbl[16];
  logic [6:0] exp_q[$];
  int         total = 0;
  int         bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Team decoder reference: syndrome is the 1-based position of a single flipped bit.
  function automatic logic [2:0] syndrome(input logic [6:0] c);
    syndrome[0] = c[0] ^ c[2] ^ c[4] ^ c[6];
    syndrome[1] = c[1] ^ c[2] ^ c[5] ^ c[6];
    syndrome[2] = c[3] ^ c[4] ^ c[5] ^ c[6];
  endfunction

  function automatic logic [3:0] dec_data(input logic [6:0] c);
    logic [2:0] s;
    logic [6:0] f;
    s = syndrome(c);
    f = c;
    if (s != 3'd0) f[s - 3'd1] = ~f[s - 3'd1];
    dec_data = {f[6], f[5], f[4], f[2]};
  endfunction

  // driver tasks
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_sent", sent_count, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step();
    check("rst_ready_up", in_ready, 1);
  endtask

  initial begin
    int n_push, n_pop, stall, cycles;

    tbl[0]  = '{4'h0, 7'h00}; tbl[1]  = '{4'h1, 7'h07};
    tbl[2]  = '{4'h2, 7'h19}; tbl[3]  = '{4'h3, 7'h1E};
    tbl[4]  = '{4'h4, 7'h2A}; tbl[5]  = '{4'h5, 7'h2D};
    tbl[6]  = '{4'h6, 7'h33}; tbl[7]  = '{4'h7, 7'h34};
    tbl[8]  = '{4'h8, 7'h4B}; tbl[9]  = '{4'h9, 7'h4C};
    tbl[10] = '{4'hA, 7'h52}; tbl[11] = '{4'hB, 7'h55};
    tbl[12] = '{4'hC, 7'h61}; tbl[13] = '{4'hD, 7'h66};
    tbl[14] = '{4'hE, 7'h78}; tbl[15] = '{4'hF, 7'h7F};

    rst_n = 1'b1; in_valid = 1'b0; in_data = 4'h0; out_ready = 1'b0;
    inj_en = 1'b0; inj_pos = 3'd0;
    @(negedge clk);
    do_reset();

    // Single word 0xB with a ready sink.
    in_valid = 1'b1; in_data = 4'hB; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("b_valid", out_valid, 1);
    check("b_code", out_code, 7'h55);
    step();
    check("b_sent", sent_count, 1);
    check("b_empty", out_valid, 0);

    // Fill with back-pressure, hold, then drain.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 4'h0;
    step();
    check("bp_ready1", in_ready, 1);
    check("bp_head1", out_code, 7'h00);
    in_data = 4'hF;
    step();
    in_valid = 1'b0;
    check("bp_full_ready", in_ready, 0);
    check("bp_head2", out_code, 7'h00);
    step();
    check("bp_hold", out_code, 7'h00);
    check("bp_hold_valid", out_valid, 1);
    out_ready = 1'b1;
    check("bp_full_pop_ready", in_ready, 0);
    step();
    check("bp_second", out_code, 7'h7F);
    check("bp_ready_back", in_ready, 1);
    step();
    check("bp_drained", out_valid, 0);
    check("bp_sent", sent_count, 3);

    // Streaming 20 words with a scoreboard.
    do_reset();
    n_push = 0; n_pop = 0; stall = 0; cycles = 0;
    out_ready = 1'b1; in_valid = 1'b1; in_data = tbl[0].d;
    for (int cyc = 0; cyc < 100 && n_pop < 20; cyc++) begin
      if (in_valid && !in_ready) stall++;
      if (in_valid && in_ready) begin
        exp_q.push_back(tbl[n_push % 16].code);
        n_push++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("stream_extra", 1, 0);
        else check("stream_data", out_code, exp_q.pop_front());
        n_pop++;
      end
      step();
      cycles++;
      in_valid = (n_push < 20);
      in_data  = tbl[n_push % 16].d;
    end
    in_valid = 1'b0;
    check("stream_pops", n_pop, 20);
    check("stream_stalls", stall, 0);
    check("stream_cycles", cycles, 21);
    check("stream_leftover", exp_q.size(), 0);
    check("stream_sent", sent_count, 20);

    // All 16 nibbles through the decoder, clean and with every single flip.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_data = tbl[i].d; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      check("tbl_valid", out_valid, 1);
      check("tbl_code", out_code, tbl[i].code);
      check("tbl_syn", syndrome(out_code), 0);
      check("tbl_dec", dec_data(out_code), tbl[i].d);
      for (int p = 0; p < 7; p++) begin
        logic [6:0] flip_w;
        flip_w = out_code ^ (7'b1 << p);
        check("tbl_corr", dec_data(flip_w), tbl[i].d);
      end
      step();
    end
    check("tbl_sent", sent_count, 16);

    // Error injection at push time.
    inj_en = 1'b1; inj_pos = 3'd3;
    in_valid = 1'b1; in_data = 4'hB;
    step();
    in_valid = 1'b0;
`ifdef HAM_ERR_INJECT_EN
    check("inj_pos3", out_code, 7'h51);
`else
    check("inj_pos3", out_code, 7'h55);
`endif
    step();
    inj_pos = 3'd0;
    in_valid = 1'b1; in_data = 4'hB;
    step();
    in_valid = 1'b0;
    check("inj_pos0", out_code, 7'h55);
    step();
    inj_en = 1'b0;

    // Reset while full: buffered words must vanish.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 4'h1;
    step();
    in_data = 4'h2;
    step();
    in_valid = 1'b0;
    check("mid_full", in_ready, 0);
    do_reset();
    check("mid_empty", out_valid, 0);
    in_valid = 1'b1; in_data = 4'h5; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("mid_first", out_code, 7'h2D);
    step();
    check("mid_no_stale", out_valid, 0);
    check("mid_sent", sent_count, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
